ahbl_slave_ram_model: RTL and testbench

Parametrised AHB-Lite slave memory model for simulation benches and small on-chip scratch RAM. It generalises the fixed 32-bit slave model with:
- selectable data width;
- per-direction programmable wait states and a runtime stall input;
- byte-lane writes driven by HSIZE;
- two-cycle ERROR responses for out-of-range or misaligned accesses;
- saturating access counters.
It sits behind the AHB decoder as a standard slave: HSEL from the decoder, HREADYIN from the bus mux.

---
 rtl/ahbl_pkg.sv | 21 ++
 rtl/ahbl_lane_dec.sv | 24 ++
 rtl/ahbl_slave_ram_model.sv | 123 ++++++++++++
 tb/tb_ahbl_slave_ram_model.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the slave FSM state type.
package ahbl_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ERR1 = 2'd2;
  localparam state_t ST_ERR2 = 2'd3;
endpackage

// File: rtl/ahbl_lane_dec.sv
// Byte-lane enables and alignment check for one transfer, little-endian.
module ahbl_lane_dec
  import ahbl_pkg::*;
#(
  parameter int DWIDTH = 32,
  localparam int NB = DWIDTH / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0] off,
  input  logic [2:0]    size,
  output logic [NB-1:0] be,
  output logic          misaligned
);
  int lo, n;

  always_comb begin
    lo = int'(off);
    n  = 1 << size;
    be = '0;
    for (int i = 0; i < NB; i++) be[i] = (i >= lo) && (i < lo + n);
    // oversize transfers are rejected by the caller, so only low bits matter
    misaligned = (size != HSIZE_BYTE) && ((lo % n) != 0);
  end
endmodule

// File: rtl/ahbl_slave_ram_model.sv
// AHB-Lite RAM slave: programmable read/write waits, STALL, byte-lane writes,
// two-cycle ERROR responses and saturating access counters.
module ahbl_slave_ram_model
  import ahbl_pkg::*;
#(
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 1024,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 0,
  parameter int CWIDTH  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic              HREADYIN,
  input  logic              STALL,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [CWIDTH-1:0] RD_CNT,
  output logic [CWIDTH-1:0] WR_CNT,
  output logic [CWIDTH-1:0] ERR_CNT
);
  localparam int NB = DWIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int MW = $clog2(DEPTH);
  localparam logic [CWIDTH-1:0] CMAX = '1;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t          state;
  logic            pend;
  logic            a_write;
  logic [MW-1:0]   a_widx;
  logic [NB-1:0]   a_be;
  logic [3:0]      wcnt;

  logic [NB-1:0]   be;
  logic            misaligned;
  logic            accept, err, done;
  logic [3:0]      wsel;

  ahbl_lane_dec #(.DWIDTH(DWIDTH)) u_lane (
    .off       (HADDR[OW-1:0]),
    .size      (HSIZE),
    .be        (be),
    .misaligned(misaligned)
  );

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin HREADYOUT = 1'b0; HRESP = HRESP_ERROR; end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: HREADYOUT = !(pend && STALL);
    endcase
  end

  assign done   = (state == ST_IDLE) && pend && !STALL;
  assign accept = HSEL && HREADYIN && HREADYOUT &&
                  (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign err    = (int'(HADDR >> OW) >= DEPTH) || (HSIZE > 3'(OW)) || misaligned;
  assign wsel   = HWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT);
  assign HRDATA = (done && !a_write) ? mem[a_widx] : '0;

  // Datapath: address-phase capture and write commit; memory survives reset.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      a_widx  <= HADDR[OW +: MW];
      a_write <= HWRITE;
      a_be    <= be;
    end
    if (!HRESET && done && a_write)
      for (int b = 0; b < NB; b++)
        if (a_be[b]) mem[a_widx][8*b +: 8] <= HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      pend    <= 1'b0;
      wcnt    <= '0;
      RD_CNT  <= '0;
      WR_CNT  <= '0;
      ERR_CNT <= '0;
    end else begin
      if (done && a_write  && WR_CNT != CMAX) WR_CNT <= WR_CNT + 1'b1;
      if (done && !a_write && RD_CNT != CMAX) RD_CNT <= RD_CNT + 1'b1;
      case (state)
        ST_WAIT: if (!STALL) begin
          wcnt <= wcnt - 1'b1;
          if (wcnt == 4'd1) state <= ST_IDLE;
        end
        ST_ERR1: state <= ST_ERR2;
        default: if (HREADYOUT) begin
          // IDLE and ERR2 both close their data phase here and may take a new one
          state <= ST_IDLE;
          pend  <= 1'b0;
          if (accept) begin
            if (err) begin
              state <= ST_ERR1;
              if (ERR_CNT != CMAX) ERR_CNT <= ERR_CNT + 1'b1;
            end else begin
              pend <= 1'b1;
              if (wsel != 4'd0) begin
                state <= ST_WAIT;
                wcnt  <= wsel;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahbl_slave_ram_model.sv
// Two slaves (zero-wait and RD=3/WR=2 wait) behind a shared bus, checked every
// cycle against a byte-array transfer model, plus directed literal checks.
module tb_ahbl_slave_ram_model;
  import ahbl_pkg::*;

  localparam int AW = 12, DW = 32, DEPTH = 256, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          HRESET = 1'b1, STALL = 1'b0, HWRITE = 1'b0, hsel_bus = 1'b0, sel = 1'b0;
  logic [1:0]    HTRANS = HTRANS_IDLE;
  logic [AW-1:0] HADDR = '0;
  logic [2:0]    HSIZE = 3'd2;
  logic [DW-1:0] HWDATA = '0;
  logic [1:0]    hsv;
  logic [DW-1:0] rdata [2];
  logic          rdy [2], rsp [2];
  logic [CW-1:0] rcnt [2], wcnt [2], ecnt [2];
  logic          hready;
  logic [DW-1:0] hr;

  assign hsv    = {hsel_bus & sel, hsel_bus & ~sel};
  assign hready = rdy[0] & rdy[1];
  assign hr     = rdata[0] | rdata[1];

  ahbl_slave_ram_model #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .RD_WAIT(0), .WR_WAIT(0), .CWIDTH(CW)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsv[0]), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(hready), .STALL(STALL), .HRDATA(rdata[0]),
    .HREADYOUT(rdy[0]), .HRESP(rsp[0]), .RD_CNT(rcnt[0]), .WR_CNT(wcnt[0]), .ERR_CNT(ecnt[0]));

  ahbl_slave_ram_model #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .RD_WAIT(3), .WR_WAIT(2), .CWIDTH(CW)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsv[1]), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(hready), .STALL(STALL), .HRDATA(rdata[1]),
    .HREADYOUT(rdy[1]), .HRESP(rsp[1]), .RD_CNT(rcnt[1]), .WR_CNT(wcnt[1]), .ERR_CNT(ecnt[1]));

  int npass = 0, ntot = 0, cyc = 0;
  bit chk_en = 0, rstall = 0;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, d, act, exp, $time);
  endtask

  // ---------------- reference model: one outstanding data phase per slave
  logic [7:0] mm [2][DEPTH*4];
  bit  dv [2], de [2], df [2], dwr [2];
  int  dw [2], dadr [2], dsz [2];
  int  crd [2], cwr [2], cer [2];

  function automatic int rd_wait(int d); return d == 1 ? 3 : 0; endfunction
  function automatic int wr_wait(int d); return d == 1 ? 2 : 0; endfunction

  function automatic bit e_ready(int d);
    if (!dv[d]) return 1'b1;
    if (de[d])  return !df[d];
    return (dw[d] == 0) && !STALL;
  endfunction

  function automatic logic [31:0] e_rdata(int d);
    int b;
    if (!(dv[d] && !de[d] && !dwr[d] && e_ready(d))) return 32'h0;
    b = dadr[d] & ~3;
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  always @(posedge HCLK) begin
    bit r [2];
    cyc++;
    r[0] = e_ready(0);
    r[1] = e_ready(1);
    for (int d = 0; d < 2; d++) begin
      if (HRESET) begin
        dv[d] = 0; crd[d] = 0; cwr[d] = 0; cer[d] = 0;
      end else begin
        if (dv[d] && !de[d] && r[d]) begin
          if (dwr[d]) begin
            for (int i = 0; i < (1 << dsz[d]); i++)
              mm[d][dadr[d]+i] = HWDATA[8*((dadr[d] % 4) + i) +: 8];
            if (cwr[d] < CMAX) cwr[d]++;
          end else if (crd[d] < CMAX) crd[d]++;
        end
        if (dv[d] && !de[d] && !r[d] && !STALL && dw[d] > 0) dw[d]--;
        if (dv[d] && de[d] && df[d]) df[d] = 0;
        if (r[d]) begin
          dv[d] = 0;
          if (hsv[d] && r[0] && r[1] && HTRANS[1]) begin
            dv[d]   = 1;
            dadr[d] = int'(HADDR);
            dsz[d]  = int'(HSIZE);
            dwr[d]  = HWRITE;
            de[d]   = (int'(HADDR) / 4 >= DEPTH) || (HSIZE > 3'd2) ||
                      (int'(HADDR) % (1 << HSIZE) != 0);
            df[d]   = de[d];
            dw[d]   = HWRITE ? wr_wait(d) : rd_wait(d);
            if (de[d] && cer[d] < CMAX) cer[d]++;
          end
        end
      end
    end
  end

  always @(negedge HCLK) if (chk_en) begin
    for (int d = 0; d < 2; d++) begin
      check("hreadyout", d, 32'(rdy[d]), 32'(e_ready(d)));
      check("hresp",     d, 32'(rsp[d]), 32'(dv[d] && de[d]));
      check("hrdata",    d, rdata[d], e_rdata(d));
      check("rd_cnt",    d, 32'(rcnt[d]), 32'(crd[d]));
      check("wr_cnt",    d, 32'(wcnt[d]), 32'(cwr[d]));
      check("err_cnt",   d, 32'(ecnt[d]), 32'(cer[d]));
    end
  end

  // ---------------- bus driver
  task automatic tick(); @(posedge HCLK); #1; endtask

  // Present one address phase, wait for acceptance, then drive its write data.
  // rd returns the HRDATA of the data phase that completed on acceptance.
  task automatic beat(input logic [1:0] t, input bit w, input int a, input int sz,
                      input logic [31:0] wd, output logic [31:0] rd);
    bit r = 0;
    int n = 0;
    HTRANS = t; HWRITE = w; HADDR = a[AW-1:0]; HSIZE = sz[2:0];
    rd = '0;
    do begin
      @(negedge HCLK);
      r  = hready;
      rd = hr;
      @(posedge HCLK); #1;
      STALL = rstall && ($urandom_range(0, 3) == 0);
      n++;
    end while (!r && n < 200);
    if (!r) begin ntot++; $display("FAIL beat_timeout: hreadyout low for %0d cycles, expected completion", n); end
    HWDATA = w ? wd : 32'($urandom);
  endtask

  task automatic count_low(input int stall_at, output int lows);
    bit fin = 0;
    lows = 0;
    HTRANS = HTRANS_IDLE;
    for (int c = 0; c < 50 && !fin; c++) begin
      STALL = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + 2);
      @(negedge HCLK);
      if (hready) fin = 1; else lows++;
      @(posedge HCLK); #1;
    end
    STALL = 0;
  endtask

  logic [31:0] pre [2][DEPTH];

  initial begin
    logic [31:0] rd, v;
    logic [31:0] bd [4];
    int c0, lows;

    tick(); tick();
    HRESET = 0; chk_en = 1; hsel_bus = 1;
    @(negedge HCLK);
    check("reset_ready", 0, 32'(rdy[0]), 32'd1);
    check("reset_resp",  0, 32'(rsp[0]), 32'd0);
    check("reset_rdata", 0, rdata[0], 32'd0);
    check("reset_cnt",   1, 32'({rcnt[1], wcnt[1], ecnt[1]}), 32'd0);
    tick();

    // fill both memories so every later read has a known value
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int w = 0; w < DEPTH; w++) begin
        v = $urandom; pre[d][w] = v;
        beat(HTRANS_NONSEQ, 1, w * 4, 2, v, rd);
      end
      beat(HTRANS_IDLE, 0, 0, 2, 0, rd);
      check("wr_cnt_saturated", d, 32'(wcnt[d]), 32'd15);
    end

    HRESET = 1; tick(); HRESET = 0;
    check("post_reset_wr_cnt", 0, 32'(wcnt[0]), 32'd0);
    sel = 0;

    c0 = cyc;
    beat(HTRANS_NONSEQ, 1, 'h010, 2, 32'hDEADBEEF, rd);
    beat(HTRANS_NONSEQ, 0, 'h010, 2, 0, rd);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);
    check("word_rdata",   0, rd, 32'hDEADBEEF);
    check("zero_wait_wr_rd_cycles", 0, 32'(cyc - c0), 32'd3);
    check("wr_cnt_one", 0, 32'(wcnt[0]), 32'd1);
    check("rd_cnt_one", 0, 32'(rcnt[0]), 32'd1);

    beat(HTRANS_NONSEQ, 1, 'h013, 0, 32'hAA000000, rd);
    beat(HTRANS_NONSEQ, 0, 'h010, 2, 0, rd);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);
    check("byte_lane3", 0, rd, 32'hAAADBEEF);
    beat(HTRANS_NONSEQ, 1, 'h010, 1, 32'h00001234, rd);
    beat(HTRANS_NONSEQ, 0, 'h010, 2, 0, rd);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);
    check("half_lane0", 0, rd, 32'hAAAD1234);

    sel = 1;
    beat(HTRANS_NONSEQ, 0, 'h040, 2, 0, rd);
    count_low(-1, lows);
    check("rd_wait3_low_cycles", 1, 32'(lows), 32'd3);
    beat(HTRANS_NONSEQ, 0, 'h040, 2, 0, rd);
    count_low(1, lows);
    check("rd_wait3_stall2_low_cycles", 1, 32'(lows), 32'd5);

    sel = 0;
    beat(HTRANS_NONSEQ, 0, DEPTH * 4, 2, 0, rd);
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    check("err1_resp", 0, 32'(rsp[0]), 32'd1);
    check("err1_ready", 0, 32'(rdy[0]), 32'd0);
    tick();
    @(negedge HCLK);
    check("err2_resp", 0, 32'(rsp[0]), 32'd1);
    check("err2_ready", 0, 32'(rdy[0]), 32'd1);
    tick();
    check("err_cnt_range", 0, 32'(ecnt[0]), 32'd1);
    beat(HTRANS_NONSEQ, 1, 'h011, 1, 32'hFFFFFFFF, rd);
    beat(HTRANS_NONSEQ, 0, 'h010, 2, 0, rd);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);
    check("misaligned_no_write", 0, rd, 32'hAAAD1234);
    check("err_cnt_misaligned", 0, 32'(ecnt[0]), 32'd2);
    beat(HTRANS_NONSEQ, 0, 'h018, 3, 0, rd);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);
    check("err_cnt_oversize", 0, 32'(ecnt[0]), 32'd3);

    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      beat(i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 1, 'h100 + 4 * i, 2, bd[i], rd);
    beat(HTRANS_IDLE, 0, 0, 2, 0, rd);
    check("burst_wr_cycles", 0, 32'(cyc - c0), 32'd5);
    c0 = cyc;
    beat(HTRANS_NONSEQ, 0, 'h100, 2, 0, rd);
    beat(HTRANS_SEQ,    0, 'h104, 2, 0, rd); check("burst_rd0", 0, rd, bd[0]);
    beat(HTRANS_BUSY,   0, 'h108, 2, 0, rd); check("burst_rd1", 0, rd, bd[1]);
    beat(HTRANS_SEQ,    0, 'h108, 2, 0, rd); check("busy_rdata", 0, rd, 32'd0);
    beat(HTRANS_SEQ,    0, 'h10C, 2, 0, rd); check("burst_rd2", 0, rd, bd[2]);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);     check("burst_rd3", 0, rd, bd[3]);
    check("burst_rd_cycles", 0, 32'(cyc - c0), 32'd6);

    sel = 1;
    beat(HTRANS_NONSEQ, 1, 'h020, 2, 32'h0BADF00D, rd);
    HTRANS = HTRANS_IDLE;
    HRESET = 1; tick(); HRESET = 0;
    @(negedge HCLK);
    check("rst_wait_ready", 1, 32'(rdy[1]), 32'd1);
    check("rst_wait_resp",  1, 32'(rsp[1]), 32'd0);
    check("rst_wait_cnts",  1, 32'({rcnt[1], wcnt[1], ecnt[1]}), 32'd0);
    tick();
    beat(HTRANS_NONSEQ, 0, 'h020, 2, 0, rd);
    beat(HTRANS_IDLE,   0, 0, 2, 0, rd);
    check("rst_abandons_write", 1, rd, pre[1][8]);

    rstall = 1;
    for (int k = 0; k < 400; k++) begin
      int t, sz, a;
      logic [1:0] tr;
      if ($urandom_range(0, 19) == 0) begin
        beat(HTRANS_IDLE, 0, 0, 2, 0, rd);
        sel = 1'($urandom_range(0, 1));
      end
      t  = $urandom_range(0, 9);
      tr = (t == 0) ? HTRANS_IDLE : (t == 1) ? HTRANS_BUSY : (t < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
      sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      a  = $urandom_range(0, DEPTH * 4 + 63);
      if ($urandom_range(0, 7) != 0) a = a & ~((1 << sz) - 1);
      beat(tr, 1'($urandom_range(0, 1)), a, sz, $urandom, rd);
    end
    rstall = 0;
    beat(HTRANS_IDLE, 0, 0, 2, 0, rd);
    STALL = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
